misaligned_access_sequencer: RTL
================================

Name: misaligned_access_sequencer

Overview:
- Sits between the CPU data interface and the word-wide RAM port of the memory controller.
- Turns byte, halfword and word loads and stores at any byte address into one or two word-aligned RAM accesses.
- Writes use per-byte enables; reads return data aligned and sign/zero-extended.
- Stalls the CPU through a Done handshake until the whole access has completed.

Parameters:
- MEM_AW, 14, width of the RAM word address (byte address bits [MEM_AW+1:2]).

Ports:
- CoreClock  input  1  core clock; every register updates on the rising edge
- nReset  input  1  asynchronous reset, active low
- CpuAddress  input  32  byte address of the access
- CpuWriteData  input  32  store data, right-justified
- CpuSize  input  2  access size: 00 byte, 01 half, 10 word, 11 illegal
- CpuSigned  input  1  loads: 1 = sign-extend, 0 = zero-extend
- CpuReadAssert  input  1  load request; held until Done
- CpuWriteAssert  input  1  store request; held until Done
- CpuReadData  output  32  load result; valid only while CpuDone=1
- CpuDone  output  1  one-cycle pulse: access complete
- CpuFault  output  1  high together with CpuDone when CpuSize=11
- MemAddress  output  MEM_AW  RAM word address
- MemWriteData  output  32  RAM write data, lane-aligned
- MemByteEnable  output  4  RAM byte-lane enables
- MemWriteAssert  output  1  RAM write strobe
- MemReadAssert  output  1  RAM read strobe
- MemReadData  input  32  RAM read data; valid in the cycle after MemReadAssert (synchronous RAM)

Behaviour:
- Reset (asynchronous, nReset=0):
  - state returns to IDLE.
  - CpuDone, CpuFault, MemReadAssert and MemWriteAssert are 0.
  - CpuReadData, MemAddress, MemWriteData and MemByteEnable are 0.
  - Reset in the middle of an access abandons it; any second RAM access is never issued.
- Derived values:
  - off = CpuAddress[1:0].
  - mask = 0001 (byte), 0011 (half) or 1111 (word).
  - wide_be[7:0] = mask << off.
  - split = |wide_be[7:4]. Splits occur for a word at off≠0 and for a half at off=3; a byte never splits.
- Simultaneous CpuReadAssert and CpuWriteAssert: the write has priority and the read is ignored.
- States: IDLE, ACC1, ACC2.
- IDLE:
  - With a request present and CpuSize≠11, drive the first access combinationally:
    - MemAddress = CpuAddress[MEM_AW+1:2]
    - MemByteEnable = wide_be[3:0]
    - MemWriteData = (CpuWriteData << 8·off)[31:0]
    - the strobe matching the request type
  - Register off, size, signed, type, split, the word address and the upper 32 bits of the shifted write data. Go to ACC1.
  - With CpuSize=11: no RAM access; CpuDone=1 and CpuFault=1 in the same cycle; stay in IDLE.
- ACC1:
  - Capture MemReadData into the lo buffer.
  - If split, issue the second access: word address + 1 (wraps modulo 2^MEM_AW), MemByteEnable = wide_be[7:4], the registered upper write data. Go to ACC2.
  - Otherwise assert CpuDone and go to IDLE.
- ACC2: assert CpuDone and go to IDLE.
- CpuReadData is combinational in the Done cycle:
  - assembled = {MemReadData, lo} >> 8·off (non-split: hi = MemReadData, lo = MemReadData for ACC1).
  - The result is truncated to size and extended according to CpuSigned.
  - It is 0 for writes.
- Latency from request to CpuDone: 1 cycle for non-split accesses, 2 cycles for split accesses.
- The CPU samples CpuDone and must change or drop its request in the following cycle. A request still held in IDLE is treated as a new access.
- Strobes and CpuDone are single-cycle; no strobe is asserted in the CpuDone cycle except during a fault.

Decomposition:
- Package mem_access_pkg holds:
  - access_size_t enum (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILLEGAL)
  - seq_state_t enum (IDLE, ACC1, ACC2)
  - function size_mask()
- Sub-module lane_align: purely combinational. Computes wide_be, the 64-bit write shift, and read extraction plus extension. Instantiated once.

Test Plan:
- Setup: RAM word 0x40 = 0x44332211, word 0x41 = 0x88776655.
- Aligned word read at 0x100 -> one MemReadAssert at word 0x40, BE 1111; CpuDone at cycle 1; CpuReadData = 0x44332211.
- Split word read at 0x101 -> reads at words 0x40 then 0x41; CpuDone at cycle 2; CpuReadData = 0x55443322.
- Signed byte read at 0x107 -> CpuReadData = 0xFFFFFF88. The same read with CpuSigned=0 -> 0x00000088. Half read at 0x103 -> split, 0x00005544.
- Split word write 0xAABBCCDD at 0x102 -> word 0x40 written with BE 1100, data 0xCCDD0000; word 0x41 written with BE 0011, data 0x0000AABB; CpuDone at cycle 2.
- CpuSize=11 read -> CpuDone=CpuFault=1 in the same cycle, no RAM strobe. Wrap case: word read at byte address (2^(MEM_AW+2))−2 -> second access at word 0.
- nReset pulsed in ACC1 of a split write -> no second MemWriteAssert, all outputs 0, state IDLE; the next request proceeds normally.

Source files
------------

// File: rtl/mem_access_pkg.sv
// ---------------------------------------------------------------------------
// mem_access_pkg
// Shared types and helpers for the misaligned access sequencer.
//   access_size_t : CPU access size encoding (byte / half / word / illegal)
//   seq_state_t   : sequencer state encoding (IDLE, ACC1, ACC2)
//   size_mask()   : byte-lane mask of an access before lane shifting
// ---------------------------------------------------------------------------
package mem_access_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE    = 2'b00,
        SZ_HALF    = 2'b01,
        SZ_WORD    = 2'b10,
        SZ_ILLEGAL = 2'b11
    } access_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ACC1 = 2'b01,
        ACC2 = 2'b10
    } seq_state_t;

    // Unshifted byte-enable mask; the illegal size enables no lane.
    function automatic logic [3:0] size_mask(input access_size_t size);
        logic [3:0] mask;
        case (size)
            SZ_BYTE: mask = 4'b0001;
            SZ_HALF: mask = 4'b0011;
            SZ_WORD: mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/lane_align.sv
// ---------------------------------------------------------------------------
// lane_align
// Purely combinational byte-lane steering for the access sequencer.
// Ports:
//   off_i        : byte offset within the word (address bits [1:0])
//   size_i       : access size
//   signed_i     : 1 = sign-extend loads, 0 = zero-extend
//   wdata_i      : right-justified store data
//   rd_hi_i      : read data of the upper (second) word
//   rd_lo_i      : read data of the lower (first) word
//   wide_be_o    : byte enables across two adjacent words ([3:0] first word)
//   wdata_wide_o : store data shifted into lanes across two words
//   rdata_o      : load result, aligned, truncated and extended
// ---------------------------------------------------------------------------
module lane_align
    import mem_access_pkg::*;
(
    input  logic [1:0]   off_i,
    input  access_size_t size_i,
    input  logic         signed_i,
    input  logic [31:0]  wdata_i,
    input  logic [31:0]  rd_hi_i,
    input  logic [31:0]  rd_lo_i,
    output logic [7:0]   wide_be_o,
    output logic [63:0]  wdata_wide_o,
    output logic [31:0]  rdata_o
);

    logic [31:0] rword_s;

    // Lane shifting for both directions plus load extension.
    always_comb begin
        wide_be_o    = {4'b0000, size_mask(size_i)} << off_i;
        wdata_wide_o = {32'h0000_0000, wdata_i} << {off_i, 3'b000};
        // The two words form a 64-bit window; shifting right by the offset
        // brings the first requested byte down to lane 0.
        rword_s      = 32'({rd_hi_i, rd_lo_i} >> {off_i, 3'b000});
        case (size_i)
            SZ_BYTE: rdata_o = {{24{signed_i & rword_s[7]}}, rword_s[7:0]};
            SZ_HALF: rdata_o = {{16{signed_i & rword_s[15]}}, rword_s[15:0]};
            SZ_WORD: rdata_o = rword_s;
            default: rdata_o = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/misaligned_access_sequencer.sv
// ---------------------------------------------------------------------------
// misaligned_access_sequencer
// Converts CPU byte/half/word loads and stores at any byte address into one
// or two word-aligned accesses on a synchronous word-wide RAM port, and
// stalls the CPU until a one-cycle CpuDone pulse.
// Ports:
//   CoreClock, nReset           : clock, asynchronous active-low reset
//   CpuAddress/CpuWriteData     : byte address, right-justified store data
//   CpuSize/CpuSigned           : size (11 illegal), load extension mode
//   CpuReadAssert/WriteAssert   : held requests (write wins if both)
//   CpuReadData/CpuDone/Fault   : load result, completion pulse, size fault
//   MemAddress/WriteData/BE     : RAM word address, lane data, byte enables
//   MemWriteAssert/ReadAssert   : RAM strobes
//   MemReadData                 : RAM data, valid the cycle after a read
// ---------------------------------------------------------------------------
module misaligned_access_sequencer
    import mem_access_pkg::*;
#(
    parameter int MEM_AW = 14
) (
    input  logic              CoreClock,
    input  logic              nReset,
    input  logic [31:0]       CpuAddress,
    input  logic [31:0]       CpuWriteData,
    input  logic [1:0]        CpuSize,
    input  logic              CpuSigned,
    input  logic              CpuReadAssert,
    input  logic              CpuWriteAssert,
    output logic [31:0]       CpuReadData,
    output logic              CpuDone,
    output logic              CpuFault,
    output logic [MEM_AW-1:0] MemAddress,
    output logic [31:0]       MemWriteData,
    output logic [3:0]        MemByteEnable,
    output logic              MemWriteAssert,
    output logic              MemReadAssert,
    input  logic [31:0]       MemReadData
);

    seq_state_t        state_q, state_d;
    logic [1:0]        off_q;
    access_size_t      size_q;
    logic              signed_q;
    logic              write_q;
    logic              split_q;
    logic [MEM_AW-1:0] waddr_q;
    logic [31:0]       wdata_hi_q;
    logic [31:0]       lo_q;

    logic              load_s;
    logic              capture_s;
    logic              req_s;
    logic [1:0]        off_s;
    access_size_t      size_s;
    logic              signed_s;
    logic [31:0]       rd_lo_s;
    logic [7:0]        wide_be_s;
    logic [63:0]       wdata_wide_s;
    logic [31:0]       rdata_ext_s;
    logic              unused_addr_s;

    assign unused_addr_s = ^CpuAddress[31:MEM_AW+2];
    assign req_s         = CpuReadAssert | CpuWriteAssert;

    // The single lane_align instance sees the live CPU request in IDLE and
    // the latched access in ACC1/ACC2.
    always_comb begin
        if (state_q == IDLE) begin
            off_s    = CpuAddress[1:0];
            size_s   = access_size_t'(CpuSize);
            signed_s = CpuSigned;
        end else begin
            off_s    = off_q;
            size_s   = size_q;
            signed_s = signed_q;
        end
        // In ACC1 both halves come straight from the RAM (non-split case).
        rd_lo_s = (state_q == ACC2) ? lo_q : MemReadData;
    end

    lane_align u_lane_align (
        .off_i        (off_s),
        .size_i       (size_s),
        .signed_i     (signed_s),
        .wdata_i      (CpuWriteData),
        .rd_hi_i      (MemReadData),
        .rd_lo_i      (rd_lo_s),
        .wide_be_o    (wide_be_s),
        .wdata_wide_o (wdata_wide_s),
        .rdata_o      (rdata_ext_s)
    );

    // Next-state and output decode; outputs are held at zero while in reset.
    always_comb begin
        state_d        = state_q;
        load_s         = 1'b0;
        capture_s      = 1'b0;
        CpuReadData    = 32'h0000_0000;
        CpuDone        = 1'b0;
        CpuFault       = 1'b0;
        MemAddress     = {MEM_AW{1'b0}};
        MemWriteData   = 32'h0000_0000;
        MemByteEnable  = 4'b0000;
        MemWriteAssert = 1'b0;
        MemReadAssert  = 1'b0;
        if (nReset) begin
            case (state_q)
                IDLE: begin
                    if (req_s && (size_s == SZ_ILLEGAL)) begin
                        CpuDone  = 1'b1;
                        CpuFault = 1'b1;
                    end else if (req_s) begin
                        MemAddress     = CpuAddress[MEM_AW+1:2];
                        MemByteEnable  = wide_be_s[3:0];
                        MemWriteData   = wdata_wide_s[31:0];
                        MemWriteAssert = CpuWriteAssert;
                        MemReadAssert  = ~CpuWriteAssert;
                        load_s         = 1'b1;
                        state_d        = ACC1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                ACC1: begin
                    capture_s = 1'b1;
                    if (split_q) begin
                        MemAddress     = waddr_q + {{(MEM_AW-1){1'b0}}, 1'b1};
                        MemByteEnable  = wide_be_s[7:4];
                        MemWriteData   = wdata_hi_q;
                        MemWriteAssert = write_q;
                        MemReadAssert  = ~write_q;
                        state_d        = ACC2;
                    end else begin
                        CpuDone     = 1'b1;
                        CpuReadData = write_q ? 32'h0000_0000 : rdata_ext_s;
                        state_d     = IDLE;
                    end
                end
                ACC2: begin
                    CpuDone     = 1'b1;
                    CpuReadData = write_q ? 32'h0000_0000 : rdata_ext_s;
                    state_d     = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end else begin
            state_d = IDLE;
        end
    end

    // State register plus the access context latched when a request starts.
    always_ff @(posedge CoreClock or negedge nReset) begin
        if (!nReset) begin
            state_q    <= IDLE;
            off_q      <= 2'b00;
            size_q     <= SZ_BYTE;
            signed_q   <= 1'b0;
            write_q    <= 1'b0;
            split_q    <= 1'b0;
            waddr_q    <= {MEM_AW{1'b0}};
            wdata_hi_q <= 32'h0000_0000;
            lo_q       <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            if (load_s) begin
                off_q      <= CpuAddress[1:0];
                size_q     <= access_size_t'(CpuSize);
                signed_q   <= CpuSigned;
                write_q    <= CpuWriteAssert;
                split_q    <= |wide_be_s[7:4];
                waddr_q    <= CpuAddress[MEM_AW+1:2];
                wdata_hi_q <= wdata_wide_s[63:32];
            end
            if (capture_s) begin
                lo_q <= MemReadData;
            end
        end
    end

endmodule
